// File: rtl/sha256_bridge_pkg.sv
// Shared types and sizing helpers for the SHA-256 host bridge.
package sha256_bridge_pkg;

  typedef enum logic {eFill, eSend}  tx_state_e;
  typedef enum logic {eIdle, eDrain} rx_state_e;

  localparam int word_width_lp    = 32;
  localparam int msg_width_lp     = 256;
  localparam int words_per_msg_lp = msg_width_lp / word_width_lp;
  localparam int word_idx_w_lp    = $clog2(words_per_msg_lp);

  // A one-word message still needs a 1-bit index register.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/sha256_digest_unpacker.sv
// Digest return path: accepts one wide digest from the engine and serializes
// it to the host MSB word first over a valid/yumi handshake.
module sha256_digest_unpacker
  import sha256_bridge_pkg::*;
#(
  parameter int word_width_p = word_width_lp,
  parameter int msg_width_p  = msg_width_lp
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    dig_v_i,
  input  logic [msg_width_p-1:0]  dig_data_i,
  output logic                    dig_yumi_o,
  output logic                    host_v_o,
  output logic [word_width_p-1:0] host_data_o,
  input  logic                    host_yumi_i
);

  localparam int words_lp = msg_width_p / word_width_p;
  localparam int idx_w_lp = idx_width(words_lp);

  rx_state_e             state_q, state_n;
  logic [idx_w_lp-1:0]   idx_q;
  logic [msg_width_p-1:0] dig_q;
  logic                  last_word;

  assign last_word = (idx_q == idx_w_lp'(words_lp - 1));

  always_comb begin
    state_n    = state_q;
    dig_yumi_o = 1'b0;
    host_v_o   = 1'b0;
    case (state_q)
      eIdle: begin
        dig_yumi_o = dig_v_i & ~reset_i;
        if (dig_v_i) state_n = eDrain;
      end
      eDrain: begin
        host_v_o = 1'b1;
        if (host_yumi_i && last_word) state_n = eIdle;
      end
      default: state_n = eIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= eIdle;
    else         state_q <= state_n;
  end

  // Shift register keeps the word currently offered to the host at the top.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dig_q <= '0;
      idx_q <= '0;
    end else if (dig_yumi_o) begin
      dig_q <= dig_data_i;
      idx_q <= '0;
    end else if (host_v_o && host_yumi_i) begin
      dig_q <= dig_q << word_width_p;
      idx_q <= idx_q + idx_w_lp'(1);
    end
  end

  assign host_data_o = dig_q[msg_width_p-1 -: word_width_p];

  a_yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) host_yumi_i |-> host_v_o);

endmodule

// File: rtl/sha256_host_bridge.sv
// Host-side bridge to the SHA-256 engine: packs host words into messages,
// meters them against a credit limit, and returns digests as host words.
module sha256_host_bridge
  import sha256_bridge_pkg::*;
#(
  parameter int word_width_p      = word_width_lp,
  parameter int msg_width_p       = msg_width_lp,
  parameter int max_outstanding_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    host_v_i,
  input  logic [word_width_p-1:0] host_data_i,
  output logic                    host_ready_o,
  output logic                    msg_v_o,
  output logic [msg_width_p-1:0]  msg_data_o,
  input  logic                    msg_ready_i,
  input  logic                    dig_v_i,
  input  logic [msg_width_p-1:0]  dig_data_i,
  output logic                    dig_yumi_o,
  output logic                    host_v_o,
  output logic [word_width_p-1:0] host_data_o,
  input  logic                    host_yumi_i,
  output logic [2:0]              outstanding_o,
  output logic                    err_o
);

  localparam int words_lp = msg_width_p / word_width_p;
  localparam int idx_w_lp = idx_width(words_lp);

  tx_state_e              tx_state_q, tx_state_n;
  logic [idx_w_lp-1:0]    word_cnt_q;
  logic [msg_width_p-1:0] msg_q;
  logic [2:0]             outstanding_q;
  logic                   err_q;
  logic                   credit_ok, word_xfer, msg_xfer, dig_dec, dig_orphan;

  assign credit_ok = (outstanding_q < 3'(max_outstanding_p));

  always_comb begin
    tx_state_n   = tx_state_q;
    host_ready_o = 1'b0;
    msg_v_o      = 1'b0;
    case (tx_state_q)
      eFill: begin
        host_ready_o = ~reset_i;
        if (host_v_i && word_cnt_q == idx_w_lp'(words_lp - 1)) tx_state_n = eSend;
      end
      eSend: begin
        msg_v_o = credit_ok;
        if (credit_ok && msg_ready_i) tx_state_n = eFill;
      end
      default: tx_state_n = eFill;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) tx_state_q <= eFill;
    else         tx_state_q <= tx_state_n;
  end

  assign word_xfer = host_v_i & host_ready_o;
  assign msg_xfer  = msg_v_o & msg_ready_i;

  // Words shift in from the LSB end so the first word ends up in the MSBs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      word_cnt_q <= '0;
      msg_q      <= '0;
    end else if (word_xfer) begin
      word_cnt_q <= word_cnt_q + idx_w_lp'(1);
      msg_q      <= {msg_q[msg_width_p-word_width_p-1:0], host_data_i};
    end else if (msg_xfer) begin
      word_cnt_q <= '0;
    end
  end

  // A digest with nothing in flight is flagged but must not underflow the count.
  assign dig_dec    = dig_yumi_o & (outstanding_q != 3'd0);
  assign dig_orphan = dig_yumi_o & (outstanding_q == 3'd0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      case ({msg_xfer, dig_dec})
        2'b10:   outstanding_q <= outstanding_q + 3'd1;
        2'b01:   outstanding_q <= outstanding_q - 3'd1;
        default: outstanding_q <= outstanding_q;
      endcase
      err_q <= err_q | dig_orphan;
    end
  end

  sha256_digest_unpacker #(
    .word_width_p(word_width_p),
    .msg_width_p (msg_width_p)
  ) unpacker (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .dig_v_i    (dig_v_i),
    .dig_data_i (dig_data_i),
    .dig_yumi_o (dig_yumi_o),
    .host_v_o   (host_v_o),
    .host_data_o(host_data_o),
    .host_yumi_i(host_yumi_i)
  );

  assign msg_data_o    = msg_q;
  assign outstanding_o = outstanding_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_sha256_host_bridge.sv
// Scoreboard bench for sha256_host_bridge: directed scenarios then random traffic.
module tb_sha256_host_bridge;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         host_v_i = 1'b0;
  logic [31:0]  host_data_i = '0;
  logic         host_ready_o;
  logic         msg_v_o;
  logic [255:0] msg_data_o;
  logic         msg_ready_i = 1'b0;
  logic         dig_v_i = 1'b0;
  logic [255:0] dig_data_i = '0;
  logic         dig_yumi_o;
  logic         host_v_o;
  logic [31:0]  host_data_o;
  logic         host_yumi_i = 1'b0;
  logic [2:0]   outstanding_o;
  logic         err_o;

  int checks = 0;
  int failures = 0;

  logic [255:0] msg_exp[$];
  logic [31:0]  host_exp[$];
  int out_m = 0;
  bit err_m = 1'b0;
  int msgs_rcvd = 0;
  int digs_sent = 0;
  bit dig_hs = 1'b0;
  bit stop = 1'b0;

  always #5 clk = ~clk;

  sha256_host_bridge dut (
    .clk_i(clk), .reset_i(reset_i),
    .host_v_i(host_v_i), .host_data_i(host_data_i), .host_ready_o(host_ready_o),
    .msg_v_o(msg_v_o), .msg_data_o(msg_data_o), .msg_ready_i(msg_ready_i),
    .dig_v_i(dig_v_i), .dig_data_i(dig_data_i), .dig_yumi_o(dig_yumi_o),
    .host_v_o(host_v_o), .host_data_o(host_data_o), .host_yumi_i(host_yumi_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard / reference model: outstanding = sent - accepted (never below 0),
  // RX is busy exactly while digest words remain undelivered.
  always @(negedge clk) begin
    bit sent, acc;
    if (reset_i) begin
      msg_exp.delete();
      host_exp.delete();
      out_m = 0; err_m = 1'b0;
      msgs_rcvd = 0; digs_sent = 0; dig_hs = 1'b0;
    end else begin
      chk("outstanding", outstanding_o, out_m);
      chk("err_o", err_o, err_m);
      chk("host_ready", host_ready_o, msg_exp.size() == 0);
      chk("msg_v", msg_v_o, (msg_exp.size() != 0) && (out_m < 4));
      chk("dig_yumi", dig_yumi_o, dig_v_i && (host_exp.size() == 0));
      chk("host_v", host_v_o, host_exp.size() != 0);
      sent = msg_v_o && msg_ready_i;
      acc  = dig_v_i && dig_yumi_o;
      if (sent) begin
        if (msg_exp.size() == 0) fail_timeout("unexpected_msg");
        else chk("msg_data", msg_data_o, msg_exp.pop_front());
        msgs_rcvd++;
      end
      if (host_v_o && host_yumi_i && host_exp.size() != 0)
        chk("host_data", host_data_o, host_exp.pop_front());
      if (acc) begin
        for (int k = 0; k < 8; k++) host_exp.push_back(dig_data_i[255-32*k -: 32]);
        digs_sent++;
        if (out_m == 0) err_m = 1'b1;
      end
      dig_hs = acc;
      out_m = out_m + int'(sent) - int'(acc && out_m > 0);
    end
  end

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    host_v_i = 1'b1;
    host_data_i = w;
    @(negedge clk);
    while (!host_ready_o && n < 500) begin @(negedge clk); n++; end
    if (!host_ready_o) fail_timeout("host_ready_wait");
    tick();
    host_v_i = 1'b0;
  endtask

  task automatic send_msg(input logic [255:0] m);
    for (int k = 0; k < 8; k++) send_word(m[255-32*k -: 32]);
    msg_exp.push_back(m);
  endtask

  task automatic give_digest(input logic [255:0] d);
    int n = 0;
    dig_v_i = 1'b1;
    dig_data_i = d;
    @(negedge clk);
    while (!dig_yumi_o && n < 200) begin @(negedge clk); n++; end
    if (!dig_yumi_o) fail_timeout("dig_yumi_wait");
    tick();
    dig_v_i = 1'b0;
  endtask

  task automatic drain_words(input logic [255:0] d, input int n, input int stall_idx);
    for (int j = 0; j < n; j++) begin
      int t = 0;
      while (!host_v_o && t < 100) begin tick(); t++; end
      if (!host_v_o) begin fail_timeout("host_v_wait"); return; end
      if (j == stall_idx) begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_data", host_data_o, d[255-32*j -: 32]);
          tick();
        end
      end
      chk("drain_word", host_data_o, d[255-32*j -: 32]);
      host_yumi_i = 1'b1;
      tick();
      host_yumi_i = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] m, d;
    int t;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_host_ready", host_ready_o, 0);
    chk("rst_msg_v", msg_v_o, 0);
    chk("rst_host_v", host_v_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_msg_data", msg_data_o, 0);
    tick();
    reset_i = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", host_ready_o, 1);
    tick();

    // 1: basic pack
    msg_ready_i = 1'b1;
    m = {32'h61626380, 192'h0, 32'h00000018};
    send_msg(m);
    @(negedge clk);
    chk("t1_msg_v", msg_v_o, 1);
    chk("t1_msg_data", msg_data_o, m);
    @(negedge clk);
    chk("t1_outstanding", outstanding_o, 1);
    tick();

    // 2: engine backpressure
    msg_ready_i = 1'b0;
    m = rand256();
    send_msg(m);
    repeat (5) begin
      @(negedge clk);
      chk("t2_msg_v_hold", msg_v_o, 1);
      chk("t2_msg_stable", msg_data_o, m);
      chk("t2_ready_low", host_ready_o, 0);
    end
    tick();
    msg_ready_i = 1'b1;
    tick();
    @(negedge clk);
    chk("t2_msg_v_done", msg_v_o, 0);
    chk("t2_outstanding", outstanding_o, 2);
    tick();

    // 3: digest drain with host stall on word 2
    d = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
         32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    give_digest(d);
    drain_words(d, 8, 2);

    // 4: credit limit
    repeat (3) send_msg(rand256());
    tick();
    send_msg(rand256());
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall_v", msg_v_o, 0);
      chk("t4_out4", outstanding_o, 4);
    end
    tick();
    d = rand256();
    give_digest(d);
    @(negedge clk);
    chk("t4_out3", outstanding_o, 3);
    chk("t4_msg_v_rise", msg_v_o, 1);
    @(negedge clk);
    chk("t4_out4_again", outstanding_o, 4);
    tick();
    drain_words(d, 8, -1);

    // 5: simultaneous send and digest accept, then orphan digest
    repeat (2) begin d = rand256(); give_digest(d); drain_words(d, 8, -1); end
    msg_ready_i = 1'b0;
    send_msg(rand256());
    d = rand256();
    dig_data_i = d;
    dig_v_i = 1'b1;
    msg_ready_i = 1'b1;
    @(negedge clk);
    chk("t5_both_hs", {dig_yumi_o, msg_v_o}, 2'b11);
    tick();
    dig_v_i = 1'b0;
    @(negedge clk);
    chk("t5_out_same", outstanding_o, 2);
    tick();
    drain_words(d, 8, -1);
    repeat (2) begin d = rand256(); give_digest(d); drain_words(d, 8, -1); end
    d = rand256();
    give_digest(d);
    @(negedge clk);
    chk("t5_err", err_o, 1);
    chk("t5_out_zero", outstanding_o, 0);
    tick();
    drain_words(d, 8, -1);

    // 6: asynchronous reset mid-pack and mid-drain
    d = rand256();
    give_digest(d);
    drain_words(d, 4, -1);
    for (int k = 0; k < 3; k++) send_word($urandom);
    #2;
    reset_i = 1'b1;
    #1;
    chk("t6_ready0", host_ready_o, 0);
    chk("t6_msg_v0", msg_v_o, 0);
    chk("t6_msg_data0", msg_data_o, 0);
    chk("t6_dig_yumi0", dig_yumi_o, 0);
    chk("t6_host_v0", host_v_o, 0);
    chk("t6_host_data0", host_data_o, 0);
    chk("t6_out0", outstanding_o, 0);
    chk("t6_err0", err_o, 0);
    tick();
    reset_i = 1'b0;
    @(negedge clk);
    chk("t6_ready1", host_ready_o, 1);
    tick();
    m = rand256();
    send_msg(m);
    @(negedge clk);
    chk("t6_repack", msg_data_o, m);
    tick();

    // Random concurrent traffic
    fork
      begin
        for (int i = 0; i < 12; i++) send_msg(rand256());
        t = 0;
        while (!(msg_exp.size() == 0 && host_exp.size() == 0 &&
                 msgs_rcvd == digs_sent && !dig_v_i) && t < 4000) begin
          tick(); t++;
        end
        if (t >= 4000) fail_timeout("random_quiesce");
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          tick();
          msg_ready_i = 1'($urandom_range(0, 1));
          host_yumi_i = host_v_o && ($urandom_range(0, 3) != 0);
          if (dig_hs) dig_v_i = 1'b0;
          if (!dig_v_i && msgs_rcvd > digs_sent && $urandom_range(0, 2) == 0) begin
            dig_data_i = rand256();
            dig_v_i = 1'b1;
          end
        end
      end
    join
    host_yumi_i = 1'b0;
    msg_ready_i = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
